dmover_mm2s_sched: RTL and testbench

Command scheduler sharing one AXI DataMover MM2S command channel between `N_REQ` requesters (weight loader, feature loader, debug reader). Accepts per-requester read jobs (address, byte length), arbitrates round-robin, splits each job into commands of at most `MAX_BTT` bytes, and formats the 72-bit DataMover command word. It limits in-flight commands, consumes the MM2S status stream, and reports per-job completion and error back to the requester.

---
 rtl/dmover_mm2s_sched.sv | 243 ++++++++++++++++++++++++
 tb/tb_dmover_mm2s_sched.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmover_mm2s_sched.sv
`default_nettype none
// ============================================================================
//  Module   : dmover_mm2s_sched
//  Purpose  : Shares one AXI DataMover MM2S command channel between N_REQ
//             requesters. Jobs (address, byte length) are accepted per
//             requester, arbitrated round-robin and split into commands of
//             at most MAX_BTT bytes. The number of commands in flight is
//             capped at MAX_OUTSTANDING. The status stream is consumed, and
//             each requester receives a done/error pulse per job.
//  Ports    : clk, rst (sync, active-high)
//             req_valid/req_ready/req_addr/req_len : per-requester job input
//             req_done/req_err                     : per-requester completion
//             m_axis_mm2s_cmd_*                    : 72-bit DataMover command
//             s_axis_mm2s_sts_*                    : 8-bit DataMover status
//  Options  : `define DMOVER_SCHED_ERR_ABORT_EN to stop issuing new chunks of
//             a job after its first non-OKAY status.
//  Revision : 1.0 - initial release
// ============================================================================
module dmover_mm2s_sched #(
    parameter int N_REQ           = 2,
    parameter int MAX_BTT         = 4096,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req_valid,
    output logic [N_REQ-1:0]     req_ready,
    input  logic [32*N_REQ-1:0]  req_addr,
    input  logic [23*N_REQ-1:0]  req_len,
    output logic [N_REQ-1:0]     req_done,
    output logic [N_REQ-1:0]     req_err,
    output logic [71:0]          m_axis_mm2s_cmd_tdata,
    output logic                 m_axis_mm2s_cmd_tvalid,
    input  logic                 m_axis_mm2s_cmd_tready,
    input  logic [7:0]           s_axis_mm2s_sts_tdata,
    input  logic                 s_axis_mm2s_sts_tvalid,
    output logic                 s_axis_mm2s_sts_tready
);

    localparam logic [22:0] C_MAX_BTT   = 23'(MAX_BTT);
    localparam logic [3:0]  C_MAX_OUT   = 4'(MAX_OUTSTANDING);
    // Starting "after" the last index makes requester 0 win the first grant.
    localparam logic [1:0]  C_LAST_INIT = 2'(N_REQ - 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_CMD  = 1'b1;

    // Slot state. Arrays indexed by a tag/grant are sized to the full 2-bit
    // index range; entries at or above N_REQ stay at their reset value.
    logic [N_REQ-1:0] r_busy;
    logic [N_REQ-1:0] r_err;
    logic [N_REQ-1:0] r_done;
    logic [N_REQ-1:0] r_done_err;
    logic [31:0]      r_addr   [4];
    logic [22:0]      r_remain [4];
    logic [3:0]       r_pend   [4];
    logic [1:0]       r_chunk  [4];

    logic [3:0]  r_outstanding;
    logic [0:0]  r_state;
    logic [0:0]  w_state_nxt;
    logic [1:0]  r_grant;
    logic [1:0]  r_last;
    logic [22:0] r_btt;
    logic [71:0] r_cmd_data;
    logic        r_sts_ready;

    logic [3:0]       w_cand;
    logic             w_found;
    logic [1:0]       w_gnt;
    logic [2:0]       w_sum;
    logic             w_launch;
    logic             w_issue;
    logic [22:0]      w_btt;
    logic             w_eof;
    logic [1:0]       w_sts_slot;
    logic             w_sts_take;
    logic             w_sts_bad;
    logic [N_REQ-1:0] w_issue_vec;
    logic [N_REQ-1:0] w_take_vec;
    logic [N_REQ-1:0] w_inflight_vec;
    logic             w_sts_unused;

    // SLVERR/DECERR/INTERR detail is folded into "not OKAY".
    assign w_sts_unused = ^s_axis_mm2s_sts_tdata[6:4];

    assign w_sts_slot = s_axis_mm2s_sts_tdata[3:2];
    assign w_sts_bad  = ~s_axis_mm2s_sts_tdata[7];
    // A status for a slot with nothing pending (stray, or pre-reset) is dropped.
    assign w_sts_take = s_axis_mm2s_sts_tvalid & r_sts_ready & (r_pend[w_sts_slot] != 4'd0);

    always_comb begin
        w_cand         = '0;
        w_found        = 1'b0;
        w_gnt          = r_last;
        w_sum          = '0;
        w_state_nxt    = r_state;
        w_launch       = 1'b0;
        w_issue        = 1'b0;
        w_issue_vec    = '0;
        w_take_vec     = '0;
        w_inflight_vec = '0;

        for (int i = 0; i < N_REQ; i++) begin
            w_cand[i] = r_busy[i] & (r_remain[i] != 23'd0);
        end

        // Round-robin: first candidate found walking forward from r_last+1.
        for (int off = 1; off <= N_REQ; off++) begin
            w_sum = {1'b0, r_last} + 3'(off);
            if (w_sum >= 3'(N_REQ)) begin
                w_sum = w_sum - 3'(N_REQ);
            end
            if (!w_found && w_cand[w_sum[1:0]]) begin
                w_found = 1'b1;
                w_gnt   = w_sum[1:0];
            end
        end

        w_btt = (r_remain[w_gnt] > C_MAX_BTT) ? C_MAX_BTT : r_remain[w_gnt];
        w_eof = (r_remain[w_gnt] <= C_MAX_BTT);

        case (r_state)
            S_IDLE: begin
                if (w_found && (r_outstanding < C_MAX_OUT)) begin
                    w_launch    = 1'b1;
                    w_state_nxt = S_CMD;
                end
            end
            S_CMD: begin
                if (m_axis_mm2s_cmd_tready) begin
                    w_issue     = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        for (int i = 0; i < N_REQ; i++) begin
            w_issue_vec[i]    = w_issue && (r_grant == 2'(i));
            w_take_vec[i]     = w_sts_take && (w_sts_slot == 2'(i));
            w_inflight_vec[i] = (r_state == S_CMD) && (r_grant == 2'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy        <= '0;
            r_err         <= '0;
            r_done        <= '0;
            r_done_err    <= '0;
            r_outstanding <= '0;
            r_state       <= S_IDLE;
            r_grant       <= '0;
            r_last        <= C_LAST_INIT;
            r_btt         <= '0;
            r_cmd_data    <= '0;
            r_sts_ready   <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                r_addr[i]   <= '0;
                r_remain[i] <= '0;
                r_pend[i]   <= '0;
                r_chunk[i]  <= '0;
            end
        end else begin
            r_sts_ready <= 1'b1;
            r_state     <= w_state_nxt;

            if (w_launch) begin
                r_grant    <= w_gnt;
                r_last     <= w_gnt;
                r_btt      <= w_btt;
                r_cmd_data <= {4'b0000, w_gnt, r_chunk[w_gnt], r_addr[w_gnt],
                               1'b0, w_eof, 6'b000000, 1'b1, w_btt};
            end

            if (w_issue && !w_sts_take) begin
                r_outstanding <= r_outstanding + 4'd1;
            end else if (!w_issue && w_sts_take) begin
                r_outstanding <= r_outstanding - 4'd1;
            end

            for (int i = 0; i < N_REQ; i++) begin
                r_done[i]     <= 1'b0;
                r_done_err[i] <= 1'b0;
                if (req_valid[i] && !r_busy[i]) begin
                    r_busy[i]   <= 1'b1;
                    r_addr[i]   <= req_addr[32*i +: 32];
                    r_remain[i] <= req_len[23*i +: 23];
                    r_pend[i]   <= '0;
                    r_chunk[i]  <= '0;
                    r_err[i]    <= 1'b0;
                end else begin
                    // busy drops one cycle after the done pulse, so ready
                    // returns two edges after the final status.
                    if (r_done[i]) begin
                        r_busy[i] <= 1'b0;
                    end else if (r_busy[i] && (r_remain[i] == 23'd0) &&
                                 (r_pend[i] == 4'd0) && !w_inflight_vec[i]) begin
                        r_done[i]     <= 1'b1;
                        r_done_err[i] <= r_err[i];
                    end

                    if (w_issue_vec[i] && !w_take_vec[i]) begin
                        r_pend[i] <= r_pend[i] + 4'd1;
                    end else if (!w_issue_vec[i] && w_take_vec[i]) begin
                        r_pend[i] <= r_pend[i] - 4'd1;
                    end

                    if (w_issue_vec[i]) begin
                        r_addr[i]   <= r_addr[i] + {9'd0, r_btt};
                        // Saturate: an abort may have zeroed remain while
                        // this command was waiting for tready.
                        r_remain[i] <= (r_remain[i] > r_btt) ? (r_remain[i] - r_btt) : 23'd0;
                        r_chunk[i]  <= r_chunk[i] + 2'd1;
                    end

                    if (w_take_vec[i] && w_sts_bad) begin
                        r_err[i] <= 1'b1;
`ifdef DMOVER_SCHED_ERR_ABORT_EN
                        r_remain[i] <= '0;
`else
`endif
                    end
                end
            end
        end
    end

    generate
        for (genvar g = 0; g < N_REQ; g++) begin : g_ready
            assign req_ready[g] = ~r_busy[g] & ~rst;
        end
    endgenerate

    assign req_done               = r_done;
    assign req_err                = r_done_err;
    assign m_axis_mm2s_cmd_tvalid = (r_state == S_CMD);
    assign m_axis_mm2s_cmd_tdata  = r_cmd_data;
    assign s_axis_mm2s_sts_tready = r_sts_ready;

endmodule
`default_nettype wire

// File: tb/tb_dmover_mm2s_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dmover_mm2s_sched
//  Purpose  : Self-checking bench for dmover_mm2s_sched (N_REQ=2,
//             MAX_BTT=4096, MAX_OUTSTANDING=2). Expected commands are queued
//             when a job is started and compared against observed handshakes.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dmover_mm2s_sched;

    localparam int N_REQ   = 2;
    localparam int MAX_BTT = 4096;
    localparam int MAX_OUT = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req_valid = '0;
    logic [1:0]  req_ready;
    logic [63:0] req_addr = '0;
    logic [45:0] req_len = '0;
    logic [1:0]  req_done;
    logic [1:0]  req_err;
    logic [71:0] m_axis_mm2s_cmd_tdata;
    logic        m_axis_mm2s_cmd_tvalid;
    logic        m_axis_mm2s_cmd_tready = 1'b1;
    logic [7:0]  s_axis_mm2s_sts_tdata = '0;
    logic        s_axis_mm2s_sts_tvalid = 1'b0;
    logic        s_axis_mm2s_sts_tready;

    dmover_mm2s_sched #(
        .N_REQ(N_REQ),
        .MAX_BTT(MAX_BTT),
        .MAX_OUTSTANDING(MAX_OUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_addr(req_addr),
        .req_len(req_len),
        .req_done(req_done),
        .req_err(req_err),
        .m_axis_mm2s_cmd_tdata(m_axis_mm2s_cmd_tdata),
        .m_axis_mm2s_cmd_tvalid(m_axis_mm2s_cmd_tvalid),
        .m_axis_mm2s_cmd_tready(m_axis_mm2s_cmd_tready),
        .s_axis_mm2s_sts_tdata(s_axis_mm2s_sts_tdata),
        .s_axis_mm2s_sts_tvalid(s_axis_mm2s_sts_tvalid),
        .s_axis_mm2s_sts_tready(s_axis_mm2s_sts_tready)
    );

    always #5 clk = ~clk;

    logic [71:0] got_q [$];
    logic [71:0] exp_q [$];
    int          done_cnt [2] = '{0, 0};
    logic        done_err [2] = '{1'b0, 1'b0};
    int          tests = 0;
    int          fails = 0;

    // Monitor: sampled on the falling edge, away from the DUT's active edge.
    always @(negedge clk) begin
        if (!rst && m_axis_mm2s_cmd_tvalid && m_axis_mm2s_cmd_tready) begin
            got_q.push_back(m_axis_mm2s_cmd_tdata);
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (req_done[i]) begin
                done_cnt[i] <= done_cnt[i] + 1;
                done_err[i] <= req_err[i];
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [71:0] mk_cmd(input logic [3:0] tag, input logic [31:0] addr,
                                           input logic eof, input logic [22:0] btt);
        return {4'b0000, tag, addr, 1'b0, eof, 6'b000000, 1'b1, btt};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_sts(input logic [7:0] d);
        s_axis_mm2s_sts_tdata  = d;
        s_axis_mm2s_sts_tvalid = 1'b1;
        tick();
        s_axis_mm2s_sts_tvalid = 1'b0;
    endtask

    task automatic start_job(input int i, input logic [31:0] a, input logic [22:0] l);
        req_addr[32*i +: 32] = a;
        req_len[23*i +: 23]  = l;
        req_valid[i]         = 1'b1;
        tick();
        req_valid[i]         = 1'b0;
    endtask

    task automatic wait_got(input int n);
        for (int t = 0; t < 200 && got_q.size() < n; t++) tick();
    endtask

    task automatic wait_done(input int i, input int n);
        for (int t = 0; t < 200 && done_cnt[i] < n; t++) tick();
    endtask

    task automatic wait_tvalid();
        for (int t = 0; t < 50 && !m_axis_mm2s_cmd_tvalid; t++) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        repeat (2) tick();
        tests++; if (req_ready !== 2'b00) begin fails++; $display("FAIL reset_ready: got %b required 00", req_ready); end
        tests++; if (req_done !== 2'b00) begin fails++; $display("FAIL reset_done: got %b required 00", req_done); end
        tests++; if (req_err !== 2'b00) begin fails++; $display("FAIL reset_err: got %b required 00", req_err); end
        tests++; if (m_axis_mm2s_cmd_tvalid !== 1'b0) begin fails++; $display("FAIL reset_tvalid: got %b required 0", m_axis_mm2s_cmd_tvalid); end
        tests++; if (m_axis_mm2s_cmd_tdata !== 72'd0) begin fails++; $display("FAIL reset_tdata: got %h required 0", m_axis_mm2s_cmd_tdata); end
        tests++; if (s_axis_mm2s_sts_tready !== 1'b0) begin fails++; $display("FAIL reset_sts_tready: got %b required 0", s_axis_mm2s_sts_tready); end
        rst = 1'b0;
        tick();
        tests++; if (req_ready !== 2'b11) begin fails++; $display("FAIL post_reset_ready: got %b required 11", req_ready); end
        tests++; if (s_axis_mm2s_sts_tready !== 1'b1) begin fails++; $display("FAIL post_reset_sts_tready: got %b required 1", s_axis_mm2s_sts_tready); end
    endtask

    task automatic test_single_job();
        logic [71:0] e, g;
        int d0;
        got_q.delete(); exp_q.delete();
        d0 = done_cnt[0];
        exp_q.push_back(mk_cmd(4'h0, 32'h1000_0000, 1'b0, 23'd4096));
        exp_q.push_back(mk_cmd(4'h1, 32'h1000_1000, 1'b0, 23'd4096));
        exp_q.push_back(mk_cmd(4'h2, 32'h1000_2000, 1'b1, 23'd1808));
        start_job(0, 32'h1000_0000, 23'd10000);
        wait_got(2);
        repeat (5) tick();
        tests++; if (got_q.size() != 2) begin fails++; $display("FAIL single_cap: got %0d cmds required 2", got_q.size()); end
        send_sts(8'h80);
        wait_got(3);
        send_sts(8'h81);
        send_sts(8'h82);
        tests++; if (req_done[0] !== 1'b0) begin fails++; $display("FAIL single_done_early: got %b required 0", req_done[0]); end
        tick();
        tests++; if (req_done[0] !== 1'b1 || req_err[0] !== 1'b0) begin fails++; $display("FAIL single_done: got done=%b err=%b required 1/0", req_done[0], req_err[0]); end
        tests++; if (req_ready[0] !== 1'b0) begin fails++; $display("FAIL single_ready_hold: got %b required 0", req_ready[0]); end
        tick();
        tests++; if (req_ready[0] !== 1'b1) begin fails++; $display("FAIL single_ready_back: got %b required 1", req_ready[0]); end
        tests++; if (got_q.size() != exp_q.size()) begin fails++; $display("FAIL single_count: got %0d required %0d", got_q.size(), exp_q.size()); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tests++;
            if (got_q.size() == 0) begin fails++; $display("FAIL single_cmd: got none required %h", e); end
            else begin
                g = got_q.pop_front();
                if (g !== e) begin fails++; $display("FAIL single_cmd: got %h required %h", g, e); end
            end
        end
        repeat (3) tick();
        tests++; if (done_cnt[0] - d0 != 1) begin fails++; $display("FAIL single_done_count: got %0d required 1", done_cnt[0] - d0); end
    endtask

    task automatic test_back_to_back();
        logic [71:0] e, g;
        int d0, d1;
        do_reset();
        got_q.delete(); exp_q.delete();
        d0 = done_cnt[0]; d1 = done_cnt[1];
        exp_q.push_back(mk_cmd(4'h0, 32'h2000_0000, 1'b0, 23'd4096));
        exp_q.push_back(mk_cmd(4'h4, 32'h3000_0000, 1'b0, 23'd4096));
        exp_q.push_back(mk_cmd(4'h1, 32'h2000_1000, 1'b1, 23'd4096));
        exp_q.push_back(mk_cmd(4'h5, 32'h3000_1000, 1'b1, 23'd4096));
        req_addr  = {32'h3000_0000, 32'h2000_0000};
        req_len   = {23'd8192, 23'd8192};
        req_valid = 2'b11;
        tick();
        req_valid = 2'b00;
        for (int k = 0; k < 4; k++) begin
            wait_got(k + 1);
            if (got_q.size() > k) send_sts(8'h80 | {4'h0, got_q[k][67:64]});
        end
        wait_done(0, d0 + 1);
        wait_done(1, d1 + 1);
        tick();
        tests++; if (got_q.size() != exp_q.size()) begin fails++; $display("FAIL b2b_count: got %0d required %0d", got_q.size(), exp_q.size()); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tests++;
            if (got_q.size() == 0) begin fails++; $display("FAIL b2b_cmd: got none required %h", e); end
            else begin
                g = got_q.pop_front();
                if (g !== e) begin fails++; $display("FAIL b2b_cmd: got %h required %h", g, e); end
            end
        end
        tests++; if (done_cnt[0] - d0 != 1 || done_err[0] !== 1'b0) begin fails++; $display("FAIL b2b_done0: got cnt=%0d err=%b required 1/0", done_cnt[0] - d0, done_err[0]); end
        tests++; if (done_cnt[1] - d1 != 1 || done_err[1] !== 1'b0) begin fails++; $display("FAIL b2b_done1: got cnt=%0d err=%b required 1/0", done_cnt[1] - d1, done_err[1]); end
    endtask

    task automatic test_stall();
        logic [71:0] e, g;
        int d1;
        got_q.delete(); exp_q.delete();
        d1 = done_cnt[1];
        e = mk_cmd(4'h4, 32'h4000_0000, 1'b1, 23'd100);
        exp_q.push_back(e);
        m_axis_mm2s_cmd_tready = 1'b0;
        start_job(1, 32'h4000_0000, 23'd100);
        wait_tvalid();
        for (int c = 0; c < 5; c++) begin
            tests++;
            if (m_axis_mm2s_cmd_tvalid !== 1'b1 || m_axis_mm2s_cmd_tdata !== e) begin
                fails++; $display("FAIL stall_hold: cycle %0d got v=%b d=%h required 1/%h", c, m_axis_mm2s_cmd_tvalid, m_axis_mm2s_cmd_tdata, e);
            end
            tick();
        end
        m_axis_mm2s_cmd_tready = 1'b1;
        tick();
        m_axis_mm2s_cmd_tready = 1'b0;
        repeat (3) tick();
        tests++; if (got_q.size() != 1) begin fails++; $display("FAIL stall_count: got %0d required 1", got_q.size()); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tests++;
            if (got_q.size() == 0) begin fails++; $display("FAIL stall_cmd: got none required %h", e); end
            else begin
                g = got_q.pop_front();
                if (g !== e) begin fails++; $display("FAIL stall_cmd: got %h required %h", g, e); end
            end
        end
        m_axis_mm2s_cmd_tready = 1'b1;
        send_sts(8'h84);
        wait_done(1, d1 + 1);
        tick();
        tests++; if (done_cnt[1] - d1 != 1 || done_err[1] !== 1'b0) begin fails++; $display("FAIL stall_done: got cnt=%0d err=%b required 1/0", done_cnt[1] - d1, done_err[1]); end
    endtask

    task automatic test_outstanding();
        logic [71:0] e, g;
        int d0;
        got_q.delete(); exp_q.delete();
        d0 = done_cnt[0];
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back(mk_cmd(4'(k), 32'h5000_0000 + 32'(k * 4096), (k == 3), 23'd4096));
        end
        start_job(0, 32'h5000_0000, 23'd16384);
        wait_got(2);
        repeat (8) tick();
        tests++; if (got_q.size() != 2) begin fails++; $display("FAIL outst_cap: got %0d cmds required 2", got_q.size()); end
        tests++; if (m_axis_mm2s_cmd_tvalid !== 1'b0) begin fails++; $display("FAIL outst_tvalid: got %b required 0", m_axis_mm2s_cmd_tvalid); end
        send_sts(8'h80);
        wait_got(3);
        repeat (4) tick();
        tests++; if (got_q.size() != 3) begin fails++; $display("FAIL outst_third: got %0d cmds required 3", got_q.size()); end
        send_sts(8'h81);
        wait_got(4);
        send_sts(8'h82);
        send_sts(8'h83);
        wait_done(0, d0 + 1);
        tick();
        tests++; if (got_q.size() != exp_q.size()) begin fails++; $display("FAIL outst_count: got %0d required %0d", got_q.size(), exp_q.size()); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tests++;
            if (got_q.size() == 0) begin fails++; $display("FAIL outst_cmd: got none required %h", e); end
            else begin
                g = got_q.pop_front();
                if (g !== e) begin fails++; $display("FAIL outst_cmd: got %h required %h", g, e); end
            end
        end
        tests++; if (done_cnt[0] - d0 != 1 || done_err[0] !== 1'b0) begin fails++; $display("FAIL outst_done: got cnt=%0d err=%b required 1/0", done_cnt[0] - d0, done_err[0]); end
    endtask

    task automatic test_error();
        logic [71:0] e, g;
        int d0;
        got_q.delete(); exp_q.delete();
        d0 = done_cnt[0];
        exp_q.push_back(mk_cmd(4'h0, 32'h6000_0000, 1'b0, 23'd4096));
        exp_q.push_back(mk_cmd(4'h1, 32'h6000_1000, 1'b0, 23'd4096));
`ifdef DMOVER_SCHED_ERR_ABORT_EN
`else
        exp_q.push_back(mk_cmd(4'h2, 32'h6000_2000, 1'b0, 23'd4096));
        exp_q.push_back(mk_cmd(4'h3, 32'h6000_3000, 1'b1, 23'd4096));
`endif
        start_job(0, 32'h6000_0000, 23'd16384);
        wait_got(2);
        repeat (3) tick();
        send_sts(8'h41);
        send_sts(8'h80);
`ifdef DMOVER_SCHED_ERR_ABORT_EN
`else
        wait_got(3);
        if (got_q.size() > 2) send_sts(8'h80 | {4'h0, got_q[2][67:64]});
        wait_got(4);
        if (got_q.size() > 3) send_sts(8'h80 | {4'h0, got_q[3][67:64]});
`endif
        wait_done(0, d0 + 1);
        repeat (5) tick();
        tests++; if (done_cnt[0] - d0 != 1 || done_err[0] !== 1'b1) begin fails++; $display("FAIL err_done: got cnt=%0d err=%b required 1/1", done_cnt[0] - d0, done_err[0]); end
        tests++; if (got_q.size() != exp_q.size()) begin fails++; $display("FAIL err_count: got %0d required %0d", got_q.size(), exp_q.size()); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tests++;
            if (got_q.size() == 0) begin fails++; $display("FAIL err_cmd: got none required %h", e); end
            else begin
                g = got_q.pop_front();
                if (g !== e) begin fails++; $display("FAIL err_cmd: got %h required %h", g, e); end
            end
        end
    endtask

    task automatic test_zero_len();
        int d1;
        got_q.delete();
        d1 = done_cnt[1];
        start_job(1, 32'h7000_0000, 23'd0);
        tick();
        tests++; if (req_done[1] !== 1'b1 || req_err[1] !== 1'b0) begin fails++; $display("FAIL zero_done: got done=%b err=%b required 1/0", req_done[1], req_err[1]); end
        repeat (4) tick();
        tests++; if (got_q.size() != 0) begin fails++; $display("FAIL zero_cmds: got %0d required 0", got_q.size()); end
        tests++; if (done_cnt[1] - d1 != 1) begin fails++; $display("FAIL zero_done_count: got %0d required 1", done_cnt[1] - d1); end
    endtask

    task automatic test_reset_mid_job();
        int d0;
        got_q.delete();
        m_axis_mm2s_cmd_tready = 1'b0;
        start_job(0, 32'h8000_0000, 23'd16384);
        wait_tvalid();
        tests++; if (m_axis_mm2s_cmd_tvalid !== 1'b1) begin fails++; $display("FAIL rstmid_pre: got tvalid %b required 1", m_axis_mm2s_cmd_tvalid); end
        rst = 1'b1;
        tick();
        tests++; if (m_axis_mm2s_cmd_tvalid !== 1'b0) begin fails++; $display("FAIL rstmid_tvalid: got %b required 0", m_axis_mm2s_cmd_tvalid); end
        tests++; if (req_ready !== 2'b00) begin fails++; $display("FAIL rstmid_ready: got %b required 00", req_ready); end
        tick();
        rst = 1'b0;
        m_axis_mm2s_cmd_tready = 1'b1;
        tick();
        d0 = done_cnt[0];
        send_sts(8'h80);
        repeat (6) tick();
        tests++; if (done_cnt[0] != d0) begin fails++; $display("FAIL rstmid_stray: got %0d done pulses required 0", done_cnt[0] - d0); end
        tests++; if (got_q.size() != 0) begin fails++; $display("FAIL rstmid_cmds: got %0d required 0", got_q.size()); end
        tests++; if (req_ready !== 2'b11) begin fails++; $display("FAIL rstmid_idle: got %b required 11", req_ready); end
    endtask

    initial begin
        test_reset();
        test_single_job();
        test_back_to_back();
        test_stall();
        test_outstanding();
        test_error();
        test_zero_len();
        test_reset_mid_job();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
